reg_wb_arbiter: RTL



---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_fifo.sv | 60 ++++++
 rtl/reg_wb_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared writeback entry type, source codes and default widths
package wb_pkg;

    localparam int WB_DATA_W     = 32;
    localparam int WB_ADDR_W     = 5;
    localparam int WB_FIFO_DEPTH = 2;

    localparam logic WB_SRC_ALU = 1'b0;
    localparam logic WB_SRC_MEM = 1'b1;

    typedef struct packed {
        logic                 src;
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - in-order pending-write buffer, two pushes and one pop per cycle
module wb_fifo #(
    parameter int ENTRY_W = 38,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_a_valid,
    input  logic [ENTRY_W-1:0] push_a_data,
    input  logic               push_b_valid,
    input  logic [ENTRY_W-1:0] push_b_data,
    input  logic               pop,
    output logic [CNT_W-1:0]   count,
    output logic [ENTRY_W-1:0] head,
    output logic               empty,
    output logic               full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] slots [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   wr_ptr_b;
    logic [PTR_W-1:0]   wr_ptr_n;
    logic [CNT_W-1:0]   count_q;
    logic [1:0]         n_push;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // push_b is only ever offered together with push_a, so it lands in the slot after it
    assign wr_ptr_b = push_a_valid ? ptr_next(wr_ptr) : wr_ptr;
    assign wr_ptr_n = push_b_valid ? ptr_next(wr_ptr_b) : wr_ptr_b;
    assign n_push   = {1'b0, push_a_valid} + {1'b0, push_b_valid};

    always_ff @(posedge clk) begin
        if (push_a_valid) slots[wr_ptr]   <= push_a_data;
        if (push_b_valid) slots[wr_ptr_b] <= push_b_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr_n;
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            count_q <= count_q + CNT_W'(n_push) - CNT_W'(pop);
        end
    end

    assign count = count_q;
    assign head  = slots[rd_ptr];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - register-file write-port scheduler (ALU vs load); optional REG_WB_PERF_EN conflict counter
module reg_wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_src,
    output logic              stall,
    output logic              pending
`ifdef REG_WB_PERF_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    logic               mem_ok;
    logic               alu_ok;
    logic [ENTRY_W-1:0] mem_entry;
    logic [ENTRY_W-1:0] alu_entry;

    logic               grant_valid;
    logic [ENTRY_W-1:0] grant_entry;
    logic               push_a_valid;
    logic [ENTRY_W-1:0] push_a_data;
    logic               push_b_valid;
    logic [ENTRY_W-1:0] push_b_data;
    logic               pop;

    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_empty;
    logic               fifo_full;

    // rd==0 writes are dropped here; an ALU request arriving under stall is dropped too
    assign mem_ok    = mem_valid && (mem_rd != '0);
    assign alu_ok    = alu_valid && (alu_rd != '0) && !fifo_full;
    assign mem_entry = {WB_SRC_MEM, mem_rd, mem_data};
    assign alu_entry = {WB_SRC_ALU, alu_rd, alu_data};

    // Age order: buffered head, then load return, then ALU result
    always_comb begin
        grant_valid  = 1'b0;
        grant_entry  = '0;
        push_a_valid = 1'b0;
        push_a_data  = '0;
        push_b_valid = 1'b0;
        push_b_data  = '0;
        pop          = 1'b0;
        if (!fifo_empty) begin
            grant_valid = 1'b1;
            grant_entry = fifo_head;
            pop         = 1'b1;
            if (mem_ok) begin
                push_a_valid = 1'b1;
                push_a_data  = mem_entry;
                push_b_valid = alu_ok;
                push_b_data  = alu_entry;
            end else if (alu_ok) begin
                push_a_valid = 1'b1;
                push_a_data  = alu_entry;
            end
        end else if (mem_ok) begin
            grant_valid  = 1'b1;
            grant_entry  = mem_entry;
            push_a_valid = alu_ok;
            push_a_data  = alu_entry;
        end else if (alu_ok) begin
            grant_valid = 1'b1;
            grant_entry = alu_entry;
        end
    end

    wb_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (FIFO_DEPTH),
        .CNT_W   (CNT_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_a_valid (push_a_valid),
        .push_a_data  (push_a_data),
        .push_b_valid (push_b_valid),
        .push_b_data  (push_b_data),
        .pop          (pop),
        .count        (fifo_count),
        .head         (fifo_head),
        .empty        (fifo_empty),
        .full         (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_src   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we                        <= grant_valid;
            {rf_src, rf_waddr, rf_wdata} <= grant_entry;
        end
    end

    assign stall   = fifo_full;
    assign pending = (fifo_count != '0);

`ifdef REG_WB_PERF_EN
    // Any push means some valid request lost arbitration this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (push_a_valid && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    alu_during_stall: assert property (@(posedge clk) disable iff (rst) !(alu_valid && stall));
`endif

endmodule
